// File: rtl/bsg_write_initiator.sv
// Register-write initiator: queues (address, data) requests in a small FIFO and
// replays each one to a register-write responder as an address strobe followed
// by a data strobe, waiting for the responder's ready between the two phases.
//
// Handshake: a request is taken on any rising edge where REQ_VALID and
// REQ_READY are both high. REQ_READY is a registered "not full" flag, so a pop
// on the same edge as a full queue only frees the slot from the next cycle on.
// READY_IN is only sampled in the two WAIT states and is ignored everywhere
// else.
module bsg_write_initiator #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 16
) (
  input  logic                  G_CLK_TX,
  input  logic                  rst,
  input  logic                  REQ_VALID,
  input  logic [DATA_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  REQ_READY,
  output logic                  VALID_OUT,
  output logic [DATA_WIDTH-1:0] ADDR_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  input  logic                  READY_IN,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PLS_W = $clog2(PULSE_CYCLES) + 1;
  localparam int WT_W  = $clog2(TIMEOUT) + 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [PLS_W-1:0] PLS_LAST  = PLS_W'(PULSE_CYCLES - 1);
  localparam logic [WT_W-1:0]  WAIT_LAST = WT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_PH,
    ADDR_WAIT,
    DATA_PH,
    DATA_WAIT
  } state_t;

  // Current phase; readable hierarchically for checkers.
  state_t state;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_data;

  logic [DATA_WIDTH-1:0]   work_data;
  logic [PLS_W-1:0]        pulse_cnt;
  logic [WT_W-1:0]         wait_cnt;

  assign head_addr = mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];

  // Queue push/pop decisions and the occupancy that results from them.
  always_comb begin
    push       = REQ_VALID && REQ_READY;
    pop        = (state == IDLE) && (count != '0);
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Request storage; contents are don't-care until written, so no reset.
  always_ff @(posedge G_CLK_TX) begin
    if (push) begin
      mem[wr_ptr] <= {REQ_ADDR, REQ_DATA};
    end
  end

  // Queue pointers, occupancy and the registered not-full flag.
  always_ff @(posedge G_CLK_TX or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      REQ_READY <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count     <= count_next;
      REQ_READY <= (count_next < CNT_FULL);
    end
  end

  // Transaction sequencer: address strobe, wait, data strobe, wait, report.
  always_ff @(posedge G_CLK_TX or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      VALID_OUT <= 1'b0;
      ADDR_OUT  <= '0;
      DATA_OUT  <= '0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      work_data <= '0;
      pulse_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ADDR_OUT  <= head_addr;
            work_data <= head_data;
            VALID_OUT <= 1'b1;
            pulse_cnt <= '0;
            state     <= ADDR_PH;
          end
        end
        ADDR_PH: begin
          if (pulse_cnt == PLS_LAST) begin
            VALID_OUT <= 1'b0;
            wait_cnt  <= '0;
            state     <= ADDR_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PLS_W'(1);
          end
        end
        ADDR_WAIT: begin
          if (READY_IN) begin
            DATA_OUT  <= work_data;
            VALID_OUT <= 1'b1;
            pulse_cnt <= '0;
            state     <= DATA_PH;
          end else if (wait_cnt == WAIT_LAST) begin
            ERROR <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WT_W'(1);
          end
        end
        DATA_PH: begin
          if (pulse_cnt == PLS_LAST) begin
            VALID_OUT <= 1'b0;
            wait_cnt  <= '0;
            state     <= DATA_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PLS_W'(1);
          end
        end
        DATA_WAIT: begin
          if (READY_IN) begin
            DONE  <= 1'b1;
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            ERROR <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WT_W'(1);
          end
        end
        default: begin
          VALID_OUT <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_write_initiator.sv
// Bench for bsg_write_initiator: a behavioural responder drives READY_IN, a
// monitor rebuilds each transaction from the strobes and compares it with the
// scoreboard entry queued when the request was driven.
module tb_bsg_write_initiator;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int PULSE = 2;
  localparam int TMO   = 16;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_data;
  logic         req_ready;
  logic         valid_out;
  logic [W-1:0] addr_out;
  logic [W-1:0] data_out;
  logic         ready_in;
  logic         done;
  logic         error;

  bsg_write_initiator #(
    .DATA_WIDTH  (W),
    .FIFO_DEPTH  (DEPTH),
    .PULSE_CYCLES(PULSE),
    .TIMEOUT     (TMO)
  ) dut (
    .G_CLK_TX (clk),
    .rst      (rst),
    .REQ_VALID(req_valid),
    .REQ_ADDR (req_addr),
    .REQ_DATA (req_data),
    .REQ_READY(req_ready),
    .VALID_OUT(valid_out),
    .ADDR_OUT (addr_out),
    .DATA_OUT (data_out),
    .READY_IN (ready_in),
    .DONE     (done),
    .ERROR    (error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           delay;
    bit           exp_err;
  } vec_t;

  vec_t         vecs[6];
  logic [2*W:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  int           resp_delay = 0;
  int           low_cnt = 0;
  int           phase = 0;
  int           hi_cnt = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] cur_addr = '0;
  logic [W-1:0] cur_data = '0;
  logic [W-1:0] resp_reg [256];
  int           done_seen = 0;
  int           err_seen = 0;
  int           rise_seen = 0;
  int           rise_cyc = 0;
  int           push_cyc = 0;
  int           wait_entry_cyc = 0;
  int           err_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- responder model ----------------
  // Drops ready while a strobe is up, raises it resp_delay clocks after it ends.
  initial begin
    ready_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || valid_out) begin
        ready_in = 1'b0;
        low_cnt  = 0;
      end else if (!ready_in) begin
        if (low_cnt >= resp_delay) ready_in = 1'b1;
        low_cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*W:0] got;
    logic [2*W:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase      = 0;
        hi_cnt     = 0;
        prev_valid = 1'b0;
      end else begin
        if (valid_out) begin
          if (!prev_valid) begin
            phase++;
            rise_seen++;
            hi_cnt = 0;
            if (phase == 1) begin
              cur_addr = addr_out;
              rise_cyc = cyc;
            end else begin
              check("addr_hold", 32'(addr_out), 32'(cur_addr));
              cur_data = data_out;
              resp_reg[cur_addr] = data_out;
            end
          end
          hi_cnt++;
        end else if (prev_valid) begin
          check("pulse_width", hi_cnt, PULSE);
          if (phase == 1) wait_entry_cyc = cyc;
        end
        if (done || error) begin
          check("done_error_exclusive", 32'(done & error), 0);
          got = error ? {1'b1, cur_addr, {W{1'b0}}} : {1'b0, cur_addr, cur_data};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got %0h with empty queue", got);
          end else begin
            exp = exp_q.pop_front();
            check("scoreboard", 32'(got), 32'(exp));
          end
          if (error) begin
            err_seen++;
            err_cyc = cyc;
          end else begin
            done_seen++;
          end
          phase = 0;
        end
        prev_valid = valid_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] d, input bit exp_err);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready stuck at 0 for addr %0h", a);
      req_valid = 1'b0;
    end else begin
      exp_q.push_back({exp_err, a, exp_err ? {W{1'b0}} : d});
      @(posedge clk);
      #1;
      push_cyc  = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int before_d;
    int before_e;
    int before_r;
    int n;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 256; i++) resp_reg[i] = '0;

    vecs[0] = '{addr: 8'h11, data: 8'hA5, delay: 0,  exp_err: 1'b0};
    vecs[1] = '{addr: 8'h22, data: 8'h5A, delay: 3,  exp_err: 1'b0};
    vecs[2] = '{addr: 8'hFF, data: 8'h00, delay: 15, exp_err: 1'b0};
    vecs[3] = '{addr: 8'h00, data: 8'hFF, delay: 1,  exp_err: 1'b0};
    vecs[4] = '{addr: 8'h33, data: 8'h44, delay: 16, exp_err: 1'b1};
    vecs[5] = '{addr: 8'h7E, data: 8'h81, delay: 2,  exp_err: 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_addr_out", 32'(addr_out), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 1);

    // Table: single writes into an idle, empty queue with varied responder delay.
    for (int i = 0; i < 6; i++) begin
      resp_delay = vecs[i].delay;
      push_req(vecs[i].addr, vecs[i].data, vecs[i].exp_err);
      wait_drain(200);
      check("latency", rise_cyc - push_cyc, 1);
      if (!vecs[i].exp_err) check("resp_reg", 32'(resp_reg[vecs[i].addr]), 32'(vecs[i].data));
    end

    // Back-to-back pushes on consecutive clocks.
    resp_delay = 0;
    before_d = done_seen;
    push_req(8'h10, 8'h01, 1'b0);
    push_req(8'h11, 8'h02, 1'b0);
    push_req(8'h12, 8'h03, 1'b0);
    wait_drain(200);
    check("b2b_done_count", done_seen - before_d, 3);

    // Timeout in the address wait, then the queued request still runs.
    resp_delay = 1000;
    before_d = done_seen;
    before_e = err_seen;
    push_req(8'h40, 8'h41, 1'b1);
    push_req(8'h50, 8'h51, 1'b0);
    n = 0;
    while (err_seen == before_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_seen", err_seen - before_e, 1);
    check("timeout_latency", err_cyc - wait_entry_cyc, TMO);
    check("timeout_no_done", done_seen - before_d, 0);
    resp_delay = 0;
    wait_drain(200);

    // Full queue: one in flight plus DEPTH stored; the next waits for a pop.
    resp_delay = 1000;
    before_e = err_seen;
    push_req(8'h70, 8'h80, 1'b1);
    push_req(8'h71, 8'h81, 1'b0);
    push_req(8'h72, 8'h82, 1'b0);
    push_req(8'h73, 8'h83, 1'b0);
    push_req(8'h74, 8'h84, 1'b0);
    check("full_ready_low", 32'(req_ready), 0);
    @(negedge clk);
    check("full_ready_held", 32'(req_ready), 0);
    push_req(8'h75, 8'h85, 1'b0);
    check("accept_after_pop", err_seen - before_e, 1);
    resp_delay = 0;
    wait_drain(400);

    // Wrap-around: ten writes through a four-entry queue.
    before_d = done_seen;
    for (int i = 0; i < 10; i++) begin
      push_req(W'(8'h90 + i), W'(8'h01 + i), 1'b0);
    end
    wait_drain(500);
    check("wrap_done_count", done_seen - before_d, 10);

    // Reset in the middle of a data strobe with another request queued.
    push_req(8'hC0, 8'hC1, 1'b0);
    push_req(8'hC2, 8'hC3, 1'b0);
    n = 0;
    while (!(valid_out && phase == 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("data_phase_reached", 32'(valid_out && phase == 2), 1);
    #2 rst = 1'b1;
    #1;
    check("async_valid_out", 32'(valid_out), 0);
    check("async_addr_out", 32'(addr_out), 0);
    check("async_data_out", 32'(data_out), 0);
    check("async_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    @(negedge clk);
    check("ready_low_in_reset", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    before_d = done_seen;
    before_e = err_seen;
    before_r = rise_seen;
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 1);
    repeat (30) @(negedge clk);
    check("no_completion_after_reset", (done_seen - before_d) + (err_seen - before_e), 0);
    check("fifo_empty_after_reset", rise_seen - before_r, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
